// File: rtl/cam_init_seq.sv
// Camera register-init sequencer: walks CAM_INIT_TBL and issues {addr,data}
// write requests to the I2C master, with delay entries, NACK retry and status.
package top_pkg;
  localparam int CAM_TBL_DEPTH = 64;
  // {reg_addr[15:0], data[7:0]}; 16'hFFFF = delay (data ms), 16'hFFFE = end of table
  localparam logic [23:0] CAM_INIT_TBL [CAM_TBL_DEPTH] = '{
    0:       24'h3008_82,
    1:       24'hFFFF_02,
    2:       24'h3100_55,
    default: 24'hFFFE_00
  };
endpackage

module cam_init_seq #(
  parameter int NUM_ENTRIES  = 64,
  parameter int PWRUP_CYC    = 2_000_000,
  parameter int DLY_UNIT_CYC = 100_000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           cam_en,
  output logic                           req_valid,
  input  logic                           req_ready,
  output logic [15:0]                    req_addr,
  output logic [7:0]                     req_data,
  input  logic                           wr_done,
  input  logic                           wr_nack,
  output logic                           busy,
  output logic                           init_done,
  output logic                           init_err,
  output logic [$clog2(NUM_ENTRIES)-1:0] entry_idx
);
  localparam int IDX_W   = $clog2(NUM_ENTRIES);
  localparam int CNT_MAX = (PWRUP_CYC > 255 * DLY_UNIT_CYC) ? PWRUP_CYC : 255 * DLY_UNIT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int TBL_IW  = $clog2(top_pkg::CAM_TBL_DEPTH);
  localparam logic [15:0] ADDR_DELAY = 16'hFFFF;
  localparam logic [15:0] ADDR_END   = 16'hFFFE;

  typedef enum logic [2:0] {
    IDLE, PWRUP, FETCH, ISSUE, WAIT_DONE, DELAY, DONE, ERROR
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_dly_last;
  logic [RTY_W-1:0]   r_retry;
  logic [IDX_W-1:0]   r_idx;
  logic [15:0]        r_addr;
  logic [7:0]         r_data;
  logic               r_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [23:0]        w_entry;
  logic [15:0]        w_e_addr;
  logic [7:0]         w_e_data;
  logic [CNT_W-1:0]   w_dly_cyc;
  logic               w_last;

  // Indices beyond the physical table read as an end marker.
  always_comb begin
    w_entry = {ADDR_END, 8'h00};
    if (int'(r_idx) < top_pkg::CAM_TBL_DEPTH)
      w_entry = top_pkg::CAM_INIT_TBL[TBL_IW'(r_idx)];
  end

  assign w_e_addr  = w_entry[23:8];
  assign w_e_data  = w_entry[7:0];
  assign w_dly_cyc = CNT_W'(w_e_data) * CNT_W'(DLY_UNIT_CYC);
  assign w_last    = (r_idx == IDX_W'(NUM_ENTRIES - 1));

  // cam_en low behaves like a synchronous copy of the reset branch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dly_last <= '0;
      r_retry    <= '0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else if (!cam_en) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dly_last <= '0;
      r_retry    <= '0;
      r_idx      <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= PWRUP;
          r_busy  <= 1'b1;
          r_cnt   <= '0;
        end
        PWRUP: begin
          if (r_cnt == CNT_W'(PWRUP_CYC - 1)) begin
            r_state <= FETCH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        FETCH: begin
          if (w_e_addr == ADDR_END) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_e_addr == ADDR_DELAY) begin
            r_state    <= DELAY;
            r_cnt      <= '0;
            r_dly_last <= (w_e_data == 8'd0) ? '0 : w_dly_cyc - CNT_W'(1);
          end else begin
            r_state <= ISSUE;
            r_valid <= 1'b1;
            r_addr  <= w_e_addr;
            r_data  <= w_e_data;
          end
        end
        ISSUE: begin
          if (req_ready) begin
            r_state <= WAIT_DONE;
            r_valid <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (wr_done) begin
            if (!wr_nack) begin
              r_retry <= '0;
              if (w_last) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_idx   <= r_idx + IDX_W'(1);
                r_state <= FETCH;
              end
            end else if (r_retry < RTY_W'(MAX_RETRY)) begin
              r_retry <= r_retry + RTY_W'(1);
              r_valid <= 1'b1;
              r_state <= ISSUE;
            end else begin
              r_state <= ERROR;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end
          end
        end
        DELAY: begin
          if (r_cnt == r_dly_last) begin
            r_cnt <= '0;
            if (w_last) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= FETCH;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE, ERROR: begin
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_valid = r_valid;
  assign req_addr  = r_addr;
  assign req_data  = r_data;
  assign busy      = r_busy;
  assign init_done = r_done;
  assign init_err  = r_err;
  assign entry_idx = r_idx;
endmodule

// File: doc/cam_init_seq.md
CAM_INIT_SEQ -- requirements
Module: cam_init_seq

Purpose: camera register-init sequencer. Walks a constant table of {reg_addr, data} pairs and feeds write requests to the I2C master (i2c_top). Runs in the clk_100 domain.

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 64, meaning table depth; index width is $clog2(NUM_ENTRIES).
REQ-002 The block SHALL have parameter PWRUP_CYC, default 2_000_000, meaning cycles to wait after cam_en before the first write (20 ms at 100 MHz).
REQ-003 The block SHALL have parameter DLY_UNIT_CYC, default 100_000, meaning cycles per delay-entry unit (1 ms).
REQ-004 The block SHALL have parameter MAX_RETRY, default 3, meaning retries allowed per entry after a NACK.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock (clk_100).
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have port cam_en, input, 1 bit: level enable; high starts the sequence, low aborts and clears status.
REQ-008 The block SHALL have port req_valid, output, 1 bit: a write request is pending.
REQ-009 The block SHALL have port req_ready, input, 1 bit: the master accepts the request.
REQ-010 The block SHALL have ports req_addr (output, 16 bits, camera register address) and req_data (output, 8 bits, write data).
REQ-011 The block SHALL have port wr_done, input, 1 bit: one-cycle pulse marking the end of an accepted write.
REQ-012 The block SHALL have port wr_nack, input, 1 bit: NACK status, valid only when wr_done=1.
REQ-013 The block SHALL have ports busy, init_done and init_err, each output, 1 bit: status.
REQ-014 The block SHALL have port entry_idx, output, $clog2(NUM_ENTRIES) bits: index of the current entry (debug).

Function
REQ-015 The table SHALL be the constant CAM_INIT_TBL in top_pkg, with 24-bit entries {addr[15:0], data[7:0]}.
REQ-016 The sequencer SHALL treat addr 16'hFFFF as a delay entry (wait data*DLY_UNIT_CYC cycles, no I2C write) and addr 16'hFFFE as end-of-table.
REQ-017 The FSM SHALL have exactly these states: IDLE, PWRUP, FETCH, ISSUE, WAIT_DONE, DELAY, DONE, ERROR.
REQ-018 Transition IDLE->PWRUP SHALL occur when cam_en=1 is sampled; in IDLE, entry_idx=0 and the retry counter is 0.
REQ-019 PWRUP SHALL last exactly PWRUP_CYC cycles and then go to FETCH.
REQ-020 FETCH SHALL last one cycle: registers the entry, then goes to DELAY (delay entry), DONE (end marker) or ISSUE (normal entry).
REQ-021 In ISSUE the block SHALL drive req_valid=1 with req_addr/req_data stable until a clock edge with req_ready=1, then go to WAIT_DONE with req_valid=0 the next cycle.
REQ-022 req_valid SHALL never depend combinationally on req_ready.
REQ-023 In WAIT_DONE, on wr_done=1 with wr_nack=0, the block SHALL clear the retry counter, increment entry_idx and go to FETCH.
REQ-024 On wr_done=1 with wr_nack=1, the block SHALL re-enter ISSUE with the same entry if retries < MAX_RETRY (retry counter +1); otherwise it SHALL go to ERROR.
REQ-025 DELAY SHALL count data*DLY_UNIT_CYC cycles; data=0 means one cycle in DELAY; then entry_idx+1 and FETCH.
REQ-026 When entry_idx=NUM_ENTRIES-1 completes without an end marker, the FSM SHALL go to DONE; entry_idx SHALL NOT wrap.
REQ-027 DONE SHALL set init_done=1 and ERROR SHALL set init_err=1; both states hold while cam_en=1.
REQ-028 busy SHALL be 1 in PWRUP, FETCH, ISSUE, WAIT_DONE and DELAY, and 0 otherwise.
REQ-029 cam_en=0 sampled in any state SHALL force IDLE on the next cycle: req_valid=0, init_done=0, init_err=0, counters cleared; any unaccepted request is dropped.
REQ-030 wr_done pulses received in IDLE, DONE or ERROR SHALL be ignored.
REQ-031 Counters SHALL be wide enough for max(PWRUP_CYC, 255*DLY_UNIT_CYC) without overflow.

Reset
REQ-032 Asserting reset SHALL immediately force state IDLE, req_valid=0, req_addr=0, req_data=0, busy=0, init_done=0, init_err=0, entry_idx=0 and all counters to 0.
REQ-033 After reset deasserts with cam_en already 1, the sequence SHALL start normally on the first clock edge.

Verification
Common bench parameters: PWRUP_CYC=10, DLY_UNIT_CYC=4, MAX_RETRY=2. Bench table: {0x3008,0x82}, {0xFFFF,0x02}, {0x3100,0x55}, {0xFFFE,0}.
REQ-034 Nominal: cam_en=1 at edge 0, req_ready=1, wr_done 3 cycles after accept, no NACK -> req_valid first high at edge 12 with 0x3008/0x82; 8-cycle delay; then 0x3100/0x55; then init_done=1, busy=0.
REQ-035 Backpressure: req_ready held 0 for 20 cycles -> req_valid stays 1 with addr/data stable throughout; exactly one accept when req_ready rises.
REQ-036 NACK: NACK twice on 0x3100, then ACK -> three requests for 0x3100, then init_done=1.
REQ-037 NACK three times on 0x3008 -> init_err=1, init_done=0, no further requests issued.
REQ-038 Abort: cam_en dropped during DELAY -> IDLE next cycle; re-raising cam_en restarts from entry 0 after PWRUP.
REQ-039 Async reset mid-WAIT_DONE -> all outputs are at reset values before the next clock edge; a stray wr_done after release has no effect.
